// File: rtl/kinase_seq_pkg.sv
// Shared types and constants for the kinase valve sequencer.
// Holds no logic, so it has no latency and no backpressure of its own.
// All drive constants use 1 = pressurised/closed.
package kinase_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPEN,
        ST_PUMP,
        ST_CLOSE,
        ST_FLUSH,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'd0,
        OP_MIX   = 2'd1,
        OP_FLUSH = 2'd2,
        OP_RSVD  = 2'd3
    } cmd_op_t;

    localparam logic [12:0] LOAD_MASK = 13'h1FF0;
    localparam logic [12:0] MIX_MASK  = 13'h000F;

    localparam logic [2:0] PUMP_A_PATTERN [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};
    localparam logic [1:0] PUMP_B_PATTERN [2] = '{2'b01, 2'b10};

    localparam logic [12:0] CTRL_A_SAFE = 13'h1FFF;
    localparam logic [3:0]  CTRL_S_SAFE = 4'hF;
    localparam logic [2:0]  PUMP_A_SAFE = 3'h7;
    localparam logic [1:0]  PUMP_B_SAFE = 2'h3;

    // Open only the selected segment valve; every other segment stays closed.
    function automatic logic [3:0] sel_closed(input logic [1:0] sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/kinase_pump_phase_gen.sv
// Pump phase generator: walks pump_a (6-phase) or pump_b (2-phase) for count pump cycles.
// Pattern is registered and appears the cycle after start; finished flags the last cycle.
// No backpressure; abort drops the pumps back to closed on the next edge.
module kinase_pump_phase_gen
    import kinase_seq_pkg::*;
#(
    parameter int PHASE_CYCLES = 1000,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             mode_mix,
    input  logic             rev,
    input  logic [CNT_W-1:0] count,
    output logic [2:0]       pump_a,
    output logic [1:0]       pump_b,
    output logic             finished
);

    logic             running, running_nxt;
    logic             mix_q, mix_nxt;
    logic             rev_q, rev_nxt;
    logic [CNT_W-1:0] dwell, dwell_nxt;
    logic [CNT_W-1:0] cyc_left, cyc_left_nxt;
    logic [2:0]       phase, phase_nxt;
    logic [2:0]       first_phase, last_phase;
    logic             phase_end, cycle_end;

    always_comb begin
        mix_nxt      = start ? mode_mix : mix_q;
        rev_nxt      = start ? rev : rev_q;
        // Reverse stepping starts on the final phase and walks down to phase 0.
        first_phase  = rev_nxt ? (mix_nxt ? 3'd1 : 3'd5) : 3'd0;
        last_phase   = rev_q ? 3'd0 : (mix_q ? 3'd1 : 3'd5);
        phase_end    = (dwell == CNT_W'(PHASE_CYCLES - 1));
        cycle_end    = phase_end && (phase == last_phase);
        finished     = running && cycle_end && (cyc_left == CNT_W'(1));

        running_nxt  = running;
        dwell_nxt    = dwell;
        cyc_left_nxt = cyc_left;
        phase_nxt    = phase;

        if (start) begin
            running_nxt  = 1'b1;
            dwell_nxt    = '0;
            phase_nxt    = first_phase;
            cyc_left_nxt = count;
        end else if (running && (abort || finished)) begin
            running_nxt  = 1'b0;
        end else if (running) begin
            if (phase_end) begin
                dwell_nxt = '0;
                if (cycle_end) begin
                    phase_nxt    = first_phase;
                    cyc_left_nxt = cyc_left - CNT_W'(1);
                end else begin
                    phase_nxt = rev_q ? phase - 3'd1 : phase + 3'd1;
                end
            end else begin
                dwell_nxt = dwell + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running  <= 1'b0;
            mix_q    <= 1'b0;
            rev_q    <= 1'b0;
            dwell    <= '0;
            cyc_left <= '0;
            phase    <= '0;
            pump_a   <= PUMP_A_SAFE;
            pump_b   <= PUMP_B_SAFE;
        end else begin
            running  <= running_nxt;
            mix_q    <= mix_nxt;
            rev_q    <= rev_nxt;
            dwell    <= dwell_nxt;
            cyc_left <= cyc_left_nxt;
            phase    <= phase_nxt;
            pump_a   <= (running_nxt && !mix_nxt) ? PUMP_A_PATTERN[phase_nxt] : PUMP_A_SAFE;
            pump_b   <= (running_nxt && mix_nxt) ? PUMP_B_PATTERN[phase_nxt[0]] : PUMP_B_SAFE;
        end
    end

endmodule

// File: rtl/kinase_valve_sequencer.sv
// Valve sequencer: open-settle / pump / close-settle (or flush) per command, then a done pulse.
// Latency 1 + 2*SETTLE + count*phases*PHASE (flush 1 + SETTLE, bad command 1); one command at a time.
// cmd_ready is high only in IDLE; KINASE_PUMP_REVERSE_EN adds cmd_rev for reverse pump stepping.
module kinase_valve_sequencer
    import kinase_seq_pkg::*;
#(
    parameter int PHASE_CYCLES  = 1000,
    parameter int SETTLE_CYCLES = 200,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_sel,
    input  logic [CNT_W-1:0] cmd_count,
`ifdef KINASE_PUMP_REVERSE_EN
    input  logic             cmd_rev,
`endif
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [12:0]      ctrl_a,
    output logic [3:0]       ctrl_s,
    output logic [2:0]       pump_a,
    output logic [1:0]       pump_b,
    output logic [12:0]      flush_ctrl_a,
    output logic [3:0]       flush_ctrl_s,
    output logic [2:0]       flush_pump_a,
    output logic [1:0]       flush_pump_b
);

    state_t           state, state_nxt;
    cmd_op_t          op_q, op_eff;
    logic [1:0]       sel_q, sel_eff;
    logic [CNT_W-1:0] count_q, settle_cnt;
    logic             err_flag, err_flag_nxt;
    logic             accept, settle_last, pump_start, pump_finished, pump_rev;
    logic [12:0]      ctrl_a_nxt;
    logic [3:0]       ctrl_s_nxt;
    logic             flush_q, flush_nxt;
    logic [2:0]       gen_pump_a;
    logic [1:0]       gen_pump_b;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt    = state;
        err_flag_nxt = err_flag;
        accept       = 1'b0;
        pump_start   = 1'b0;
        settle_last  = (settle_cnt == CNT_W'(SETTLE_CYCLES - 1));

        case (state)
            ST_IDLE: begin
                if (cmd_valid && !abort) begin
                    accept       = 1'b1;
                    err_flag_nxt = (cmd_op == OP_RSVD) || (cmd_sel >= 4'd4);
                    if (err_flag_nxt)           state_nxt = ST_DONE;
                    else if (cmd_op == OP_FLUSH) state_nxt = ST_FLUSH;
                    else                         state_nxt = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (abort) begin
                    state_nxt    = ST_CLOSE;
                    err_flag_nxt = 1'b1;
                end else if (settle_last) begin
                    if (count_q == '0) begin
                        state_nxt = ST_CLOSE;
                    end else begin
                        state_nxt  = ST_PUMP;
                        pump_start = 1'b1;
                    end
                end
            end
            ST_PUMP: begin
                if (abort) begin
                    state_nxt    = ST_CLOSE;
                    err_flag_nxt = 1'b1;
                end else if (pump_finished) begin
                    state_nxt = ST_CLOSE;
                end
            end
            ST_CLOSE, ST_FLUSH: begin
                // Abort here cannot shorten the sequence; it only marks the result.
                if (abort)       err_flag_nxt = 1'b1;
                if (settle_last) state_nxt    = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        // Outputs are registered from the upcoming state so they line up with it.
        op_eff     = accept ? cmd_op_t'(cmd_op) : op_q;
        sel_eff    = accept ? cmd_sel[1:0] : sel_q;
        ctrl_a_nxt = CTRL_A_SAFE;
        ctrl_s_nxt = CTRL_S_SAFE;
        flush_nxt  = 1'b0;
        if (state_nxt == ST_OPEN || state_nxt == ST_PUMP) begin
            ctrl_a_nxt = (op_eff == OP_MIX) ? MIX_MASK : LOAD_MASK;
            ctrl_s_nxt = sel_closed(sel_eff);
        end else if (state_nxt == ST_FLUSH) begin
            ctrl_a_nxt = '0;
            ctrl_s_nxt = '0;
            flush_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= OP_LOAD;
            sel_q      <= '0;
            count_q    <= '0;
            settle_cnt <= '0;
            err_flag   <= 1'b0;
            ctrl_a     <= CTRL_A_SAFE;
            ctrl_s     <= CTRL_S_SAFE;
            flush_q    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            err_flag   <= err_flag_nxt;
            settle_cnt <= (state_nxt != state) ? '0 : settle_cnt + CNT_W'(1);
            if (accept) begin
                op_q    <= cmd_op_t'(cmd_op);
                sel_q   <= cmd_sel[1:0];
                count_q <= cmd_count;
            end
            ctrl_a     <= ctrl_a_nxt;
            ctrl_s     <= ctrl_s_nxt;
            flush_q    <= flush_nxt;
            done       <= (state_nxt == ST_DONE);
            err        <= (state_nxt == ST_DONE) && err_flag_nxt;
        end
    end

`ifdef KINASE_PUMP_REVERSE_EN
    logic rev_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rev_q <= 1'b0;
        else if (accept) rev_q <= cmd_rev;
    end
    assign pump_rev = rev_q;
`else
    assign pump_rev = 1'b0;
`endif

    kinase_pump_phase_gen #(
        .PHASE_CYCLES (PHASE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_phase_gen (
        .clk      (clk),
        .rst      (rst),
        .start    (pump_start),
        .abort    (abort && (state == ST_PUMP)),
        .mode_mix (op_q == OP_MIX),
        .rev      (pump_rev),
        .count    (count_q),
        .pump_a   (gen_pump_a),
        .pump_b   (gen_pump_b),
        .finished (pump_finished)
    );

    // Pump generator idles closed, so flushing only needs to mask it open.
    assign pump_a       = gen_pump_a & ~{3{flush_q}};
    assign pump_b       = gen_pump_b & ~{2{flush_q}};
    assign flush_ctrl_a = {13{flush_q}};
    assign flush_ctrl_s = {4{flush_q}};
    assign flush_pump_a = {3{flush_q}};
    assign flush_pump_b = {2{flush_q}};

endmodule

// File: tb/tb_kinase_valve_sequencer.sv
// Bench for kinase_valve_sequencer: directed and random commands checked cycle by cycle
// against a timeline model built from the command rules (PHASE_CYCLES=4, SETTLE_CYCLES=3).
module tb_kinase_valve_sequencer;

    localparam int P = 4;
    localparam int S = 3;
    localparam int W = 16;

    // {busy, cmd_ready, done, err, ctrl_a, ctrl_s, pump_a, pump_b, flush_a, flush_s, flush_pa, flush_pb}
    localparam logic [47:0] IDLE_VEC = {1'b0, 1'b1, 1'b0, 1'b0, 13'h1FFF, 4'hF, 3'h7, 2'h3,
                                        13'h0, 4'h0, 3'h0, 2'h0};

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, abort, busy, done, err;
    logic [1:0]    cmd_op;
    logic [3:0]    cmd_sel;
    logic [W-1:0]  cmd_count;
    logic [12:0]   ctrl_a, flush_ctrl_a;
    logic [3:0]    ctrl_s, flush_ctrl_s;
    logic [2:0]    pump_a, flush_pump_a;
    logic [1:0]    pump_b, flush_pump_b;

    int checks = 0;
    int errors = 0;

    logic [2:0] a_seq [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};
    logic [1:0] b_seq [2] = '{2'b01, 2'b10};

    always #5 clk = ~clk;

    kinase_valve_sequencer #(
        .PHASE_CYCLES  (P),
        .SETTLE_CYCLES (S),
        .CNT_W         (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_sel      (cmd_sel),
        .cmd_count    (cmd_count),
`ifdef KINASE_PUMP_REVERSE_EN
        .cmd_rev      (1'b0),
`endif
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .ctrl_a       (ctrl_a),
        .ctrl_s       (ctrl_s),
        .pump_a       (pump_a),
        .pump_b       (pump_b),
        .flush_ctrl_a (flush_ctrl_a),
        .flush_ctrl_s (flush_ctrl_s),
        .flush_pump_a (flush_pump_a),
        .flush_pump_b (flush_pump_b)
    );

    // Windows of a command in cycles after acceptance; ta = cycle abort is held (0 = none).
    function automatic void windows(input int op, input int sel, input int n, input int ta,
                                    output int pump_end, output int close_t,
                                    output int done_t, output bit errf);
        int np;
        np       = (op == 1) ? 2 : 6;
        pump_end = 0;
        close_t  = 0;
        errf     = 1'b0;
        if (op == 3 || sel >= 4) begin
            done_t = 1;
            errf   = 1'b1;
        end else if (op == 2) begin
            done_t = S + 1;
            errf   = (ta >= 1 && ta <= S);
        end else begin
            pump_end = S + n * np * P;
            close_t  = pump_end + 1;
            if (ta >= 1 && ta <= pump_end) begin
                pump_end = ta;
                close_t  = ta + 1;
                errf     = 1'b1;
            end
            done_t = close_t + S;
            if (ta >= close_t && ta < done_t) errf = 1'b1;
        end
    endfunction

    function automatic logic [47:0] expect_vec(input int op, input int sel, input int n,
                                               input int ta, input int t);
        int pump_end, close_t, done_t, ph;
        bit errf, valid;
        logic bsy, rdy, dn, er;
        logic [12:0] ca, fa;
        logic [3:0] cs, fs, one;
        logic [2:0] pa, fpa;
        logic [1:0] pb, fpb;
        windows(op, sel, n, ta, pump_end, close_t, done_t, errf);
        valid = !(op == 3 || sel >= 4);
        one = 4'b0001;
        bsy = (t <= done_t);
        rdy = !bsy;
        dn  = (t == done_t);
        er  = dn && errf;
        ca = 13'h1FFF; cs = 4'hF; pa = 3'h7; pb = 2'h3;
        fa = 13'h0;    fs = 4'h0; fpa = 3'h0; fpb = 2'h0;
        if (valid && op == 2 && t <= S) begin
            ca = 13'h0;    cs = 4'h0; pa = 3'h0; pb = 2'h0;
            fa = 13'h1FFF; fs = 4'hF; fpa = 3'h7; fpb = 2'h3;
        end
        if (valid && op < 2 && t < close_t) begin
            ca = (op == 0) ? 13'h1FF0 : 13'h000F;
            cs = ~(one << sel);
        end
        if (valid && op < 2 && t > S && t <= pump_end) begin
            ph = ((t - S - 1) / P) % ((op == 1) ? 2 : 6);
            if (op == 0) pa = a_seq[ph];
            else         pb = b_seq[ph];
        end
        return {bsy, rdy, dn, er, ca, cs, pa, pb, fa, fs, fpa, fpb};
    endfunction

    function automatic logic [47:0] observe();
        return {busy, cmd_ready, done, err, ctrl_a, ctrl_s, pump_a, pump_b,
                flush_ctrl_a, flush_ctrl_s, flush_pump_a, flush_pump_b};
    endfunction

    task automatic chk(input string tag, input int t, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed %h expected %h", tag, t, obs, exp);
        end
    endtask

    // Offer one command at a negedge, then check every cycle up to one past done.
    task automatic run(input int op, input int sel, input int n, input int ta, input string tag);
        int pump_end, close_t, done_t;
        bit errf;
        logic excl;
        windows(op, sel, n, ta, pump_end, close_t, done_t, errf);
        cmd_op    = op[1:0];
        cmd_sel   = sel[3:0];
        cmd_count = n[W-1:0];
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int t = 1; t <= done_t + 1; t++) begin
            chk(tag, t, observe(), expect_vec(op, sel, n, ta, t));
            excl = |(ctrl_a & flush_ctrl_a) | |(ctrl_s & flush_ctrl_s) |
                   |(pump_a & flush_pump_a) | |(pump_b & flush_pump_b);
            chk({tag, "_excl"}, t, {47'd0, excl}, 48'd0);
            abort = (t == ta);
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    initial begin
        int op, sel, n, ta, pe, ct, dt;
        bit ef;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_sel   = 4'd0;
        cmd_count = '0;
        abort     = 1'b0;
        #2 rst = 1'b1;
        #1 chk("reset_async", 0, observe(), IDLE_VEC);
        @(negedge clk);
        @(negedge clk);
        chk("reset_held", 0, observe(), IDLE_VEC);
        rst = 1'b0;
        @(negedge clk);

        run(0, 2, 2, 0, "load_s2_c2");
        run(1, 0, 0, 0, "mix_s0_c0");
        run(1, 3, 2, 0, "mix_s3_c2");
        run(2, 1, 0, 0, "flush");
        run(0, 5, 1, 0, "bad_sel");
        run(3, 0, 1, 0, "bad_op");
        run(0, 1, 1, 10, "abort_pump");
        run(1, 3, 2, 2, "abort_open");
        run(0, 0, 1, 29, "abort_close");
        run(2, 0, 0, 2, "abort_flush");
        run(1, 2, 1, 15, "abort_in_done");
        run(0, 3, 65535, 30, "abort_maxcount");

        cmd_op    = 2'd0;
        cmd_sel   = 4'd1;
        cmd_count = 16'd1;
        cmd_valid = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        chk("abort_idle_1", 0, observe(), IDLE_VEC);
        @(negedge clk);
        chk("abort_idle_2", 0, observe(), IDLE_VEC);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk);

        cmd_op    = 2'd0;
        cmd_sel   = 4'd1;
        cmd_count = 16'd3;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_reset_pump", 9, observe(), expect_vec(0, 1, 3, 0, 9));
        #2 rst = 1'b1;
        #1 chk("reset_mid_pump", 9, observe(), IDLE_VEC);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_reset", 0, observe(), IDLE_VEC);

        for (int i = 0; i < 25; i++) begin
            op  = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 4));
            n   = int'($urandom_range(0, 3));
            windows(op, sel, n, 0, pe, ct, dt, ef);
            ta  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, dt)) : 0;
            run(op, sel, n, ta, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
